// File: rtl/t05_pkg.sv
// Shared definitions for the codebook walker: FSM state set, NULL child tag
// and the child-field decode helper.
package t05_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FETCH = 4'd1,
    S_WAIT  = 4'd2,
    S_LEFT  = 4'd3,
    S_RIGHT = 4'd4,
    S_EMIT  = 4'd5,
    S_POP   = 4'd6,
    S_DONE  = 4'd7,
    S_ERR   = 4'd8
  } state_cb;

  typedef enum logic [1:0] {
    CH_LEAF = 2'd0,
    CH_NODE = 2'd1,
    CH_NULL = 2'd2
  } child_kind_e;

  localparam int CH_W_MAX = 32;

  // NULL tag for the default 9-bit child field: {2'b11, zeros}
  localparam logic [8:0] NULL_CHILD = 9'h180;

  function automatic logic [CH_W_MAX-1:0] null_child(input int ch_w);
    return CH_W_MAX'(3) << (ch_w - 2);
  endfunction

  function automatic child_kind_e child_kind(input logic [CH_W_MAX-1:0] c, input int ch_w);
    logic [CH_W_MAX-1:0] w_mask;
    logic [CH_W_MAX-1:0] w_cm;
    w_mask = (CH_W_MAX'(1) << ch_w) - CH_W_MAX'(1);
    w_cm   = c & w_mask;
    if ((w_cm >> (ch_w - 1)) == CH_W_MAX'(0)) begin
      return CH_LEAF;
    end else if (w_cm == null_child(ch_w)) begin
      return CH_NULL;
    end else begin
      return CH_NODE;
    end
  endfunction

endpackage

// File: rtl/t05_codebook_gen_stack.sv
// Synchronous LIFO holding pending right subtrees; push/pop ignored when
// full/empty, clear wins over both.
module t05_cb_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SPW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [SPW-1:0]   r_sp;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_top_idx;

  assign w_wr_idx  = AW'(r_sp);
  assign w_top_idx = AW'(r_sp - 1'b1);
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_sp == SPW'(0));
  assign o_full    = (r_sp == SPW'(DEPTH));

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_sp <= SPW'(0);
    end else if (i_clr) begin
      r_sp <= SPW'(0);
    end else if (i_push && !o_full) begin
      r_sp <= r_sp + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_sp <= r_sp - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !o_full && !i_clr) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/t05_codebook_gen.sv
// Depth-first Huffman tree walker: fetches nodes over a variable-latency read
// handshake and streams one (symbol, code, length) record per leaf.
module t05_codebook_gen
  import t05_pkg::*;
#(
  parameter int SYM_W   = 8,
  parameter int NODE_AW = 7,
  parameter int ELEM_W  = 71,
  parameter int L_LSB   = 55,
  parameter int R_LSB   = 46,
  parameter int MAX_LEN = 128
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic                          i_start,
  input  logic [NODE_AW-1:0]            i_root_idx,
  input  logic                          i_abort,
  output logic                          o_rd_req,
  output logic [NODE_AW-1:0]            o_rd_addr,
  input  logic                          i_rd_valid,
  input  logic [ELEM_W-1:0]             i_rd_data,
  output logic                          o_code_valid,
  input  logic                          i_code_ready,
  output logic [SYM_W-1:0]              o_code_sym,
  output logic [MAX_LEN-1:0]            o_code_bits,
  output logic [$clog2(MAX_LEN+1)-1:0]  o_code_len,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err
);

  localparam int CH_W  = SYM_W + 1;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int STK_W = CH_W + LEN_W;

  state_cb              r_state, w_state;
  logic [NODE_AW-1:0]   r_node, w_node;
  logic [LEN_W-1:0]     r_len, w_len;
  logic [MAX_LEN-1:0]   r_code, w_code;
  logic [CH_W-1:0]      r_left, r_right;
  logic [SYM_W-1:0]     w_sym;
  logic                 w_push, w_pop, w_clr, w_launch;
  logic [STK_W-1:0]     w_top;
  logic [CH_W-1:0]      w_top_c;
  logic [LEN_W-1:0]     w_top_d;
  logic                 w_empty, w_full;
  child_kind_e          w_l_kind, w_r_kind, w_t_kind;
  logic                 w_unused_data;

  logic                 r_rd_req, r_code_valid, r_busy, r_done, r_err;
  logic [NODE_AW-1:0]   r_rd_addr;
  logic [SYM_W-1:0]     r_code_sym;
  logic [MAX_LEN-1:0]   r_code_bits;
  logic [LEN_W-1:0]     r_code_len;

  assign w_l_kind      = child_kind(CH_W_MAX'(r_left), CH_W);
  assign w_r_kind      = child_kind(CH_W_MAX'(r_right), CH_W);
  assign w_top_c       = w_top[STK_W-1 -: CH_W];
  assign w_top_d       = w_top[LEN_W-1:0];
  assign w_t_kind      = child_kind(CH_W_MAX'(w_top_c), CH_W);
  assign w_unused_data = ^i_rd_data;

  t05_cb_stack #(
    .WIDTH (STK_W),
    .DEPTH (MAX_LEN)
  ) u_stack (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({r_right, r_len}),
    .o_top   (w_top),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Next-state, datapath and stack control for the walk.
  always_comb begin
    w_state  = r_state;
    w_node   = r_node;
    w_len    = r_len;
    w_code   = r_code;
    w_sym    = r_code_sym;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_clr    = 1'b0;
    w_launch = 1'b0;
    if (i_abort) begin
      w_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            w_state  = S_FETCH;
            w_node   = i_root_idx;
            w_len    = '0;
            w_code   = '0;
            w_clr    = 1'b1;
            w_launch = 1'b1;
          end else begin
            w_state = r_state;
          end
        end
        S_FETCH: w_state = S_WAIT;
        S_WAIT: begin
          if (i_rd_valid) begin
            w_state = S_LEFT;
          end else begin
            w_state = S_WAIT;
          end
        end
        S_LEFT: begin
          if ((w_r_kind != CH_NULL) && w_full) begin
            w_state = S_ERR;
          end else begin
            w_push = (w_r_kind != CH_NULL);
            case (w_l_kind)
              CH_NULL: w_state = S_POP;
              CH_LEAF, CH_NODE: begin
                if (r_len == LEN_W'(MAX_LEN)) begin
                  w_state = S_ERR;
                  w_push  = 1'b0;
                end else begin
                  w_len  = r_len + 1'b1;
                  w_code = {r_code[MAX_LEN-2:0], 1'b0};
                  if (w_l_kind == CH_LEAF) begin
                    w_state = S_EMIT;
                    w_sym   = r_left[SYM_W-1:0];
                  end else begin
                    w_state = S_FETCH;
                    w_node  = r_left[NODE_AW-1:0];
                  end
                end
              end
              default: w_state = S_ERR;
            endcase
          end
        end
        S_POP: begin
          if (w_empty) begin
            w_state = S_DONE;
          end else begin
            // Drop the bits below the branch point, then take its right edge.
            w_pop  = 1'b1;
            w_len  = w_top_d + 1'b1;
            w_code = ((r_code >> (r_len - w_top_d)) << 1'b1) | {{(MAX_LEN-1){1'b0}}, 1'b1};
            if (w_t_kind == CH_LEAF) begin
              w_state = S_EMIT;
              w_sym   = w_top_c[SYM_W-1:0];
            end else begin
              w_state = S_FETCH;
              w_node  = w_top_c[NODE_AW-1:0];
            end
          end
        end
        S_EMIT: begin
          if (i_code_ready) begin
            w_state = S_POP;
          end else begin
            w_state = S_EMIT;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs derived from the next state.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state      <= S_IDLE;
      r_node       <= '0;
      r_len        <= '0;
      r_code       <= '0;
      r_left       <= '0;
      r_right      <= '0;
      r_rd_req     <= 1'b0;
      r_rd_addr    <= '0;
      r_code_valid <= 1'b0;
      r_code_sym   <= '0;
      r_code_bits  <= '0;
      r_code_len   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_node       <= w_node;
      r_len        <= w_len;
      r_code       <= w_code;
      r_rd_req     <= (w_state == S_FETCH);
      r_code_valid <= (w_state == S_EMIT);
      r_busy       <= (w_state != S_IDLE) && (w_state != S_DONE) && (w_state != S_ERR);
      if ((r_state == S_WAIT) && (w_state == S_LEFT)) begin
        r_left  <= i_rd_data[L_LSB +: CH_W];
        r_right <= i_rd_data[R_LSB +: CH_W];
      end
      if (w_state == S_FETCH) begin
        r_rd_addr <= w_node;
      end
      if ((w_state == S_EMIT) && (r_state != S_EMIT)) begin
        r_code_sym  <= w_sym;
        r_code_bits <= w_code;
        r_code_len  <= w_len;
      end
      if (w_launch) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end else begin
        if (w_state == S_DONE) r_done <= 1'b1;
        if (w_state == S_ERR)  r_err  <= 1'b1;
      end
    end
  end

  assign o_rd_req     = r_rd_req;
  assign o_rd_addr    = r_rd_addr;
  assign o_code_valid = r_code_valid;
  assign o_code_sym   = r_code_sym;
  assign o_code_bits  = r_code_bits;
  assign o_code_len   = r_code_len;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule
